cut_bist_driver: RTL and testbench
==================================

// Module: cut_bist_driver
// PURPOSE
//  Sequential test harness around a generated combinational netlist (circuit-under-test, CUT) of library cells.
//  An LFSR drives pseudo-random vectors into the CUT inputs. The FSM waits a programmable settle time to cover
//  cell path delays, then captures the CUT outputs. Responses go out raw and, optionally, into a MISR signature.
// PARAMETERS
//  IN_W        8      CUT input width = LFSR width (>=2)
//  OUT_W       8      CUT output width (>=2)
//  SEED        8'h01  LFSR start value, IN_W bits; must be nonzero
//  TAPS        8'hB8  LFSR feedback mask, IN_W bits
//  MISR_TAPS   8'hB8  MISR feedback mask, OUT_W bits
//  SETTLE_CYC  2      wait cycles between vector apply and capture (0..255)
//  NUM_VEC     255    vectors per run (0..65535)
// PORTS
//  CLK         in   1      rising-edge clock
//  RST         in   1      synchronous, active-high reset
//  START       in   1      start a run; sampled only in IDLE/DONE
//  CUT_IN      out  IN_W   vector to CUT inputs = LFSR register (registered, glitch-free)
//  CUT_OUT     in   OUT_W  CUT outputs, sampled only in CAPTURE
//  BUSY        out  1      high in APPLY/SETTLE/CAPTURE
//  DONE        out  1      high in DONE state, held until next START or RST
//  VEC_CNT     out  16     vectors captured in the current run
//  RESP        out  OUT_W  last captured CUT_OUT
//  RESP_VALID  out  1      1-cycle pulse, cycle after each capture
//  SIG         out  OUT_W  MISR signature (only when CUT_BIST_MISR_EN is defined)
// BEHAVIOUR
//  Reset (RST=1 at an edge, any state incl. mid-run): IDLE; lfsr=SEED; BUSY=0, DONE=0, VEC_CNT=0,
//   RESP=0, RESP_VALID=0, SIG=0, settle counter=0. RST has priority over START.
//  LFSR step: lfsr <= {lfsr[IN_W-2:0], ^(lfsr & TAPS)}. Defaults give 01,02,04,08,11,... with period 255.
//  FSM:
//   IDLE/DONE + START: lfsr<=SEED, VEC_CNT<=0, SIG<=0, DONE<=0.
//    Next state is APPLY, or DONE if NUM_VEC==0 (DONE re-asserts on the next cycle).
//   APPLY (1 cycle): CUT_IN stable. Load settle counter with SETTLE_CYC.
//    Next state is SETTLE, or CAPTURE if SETTLE_CYC==0.
//   SETTLE: decrement the counter each cycle; go to CAPTURE on the cycle the counter reaches 0.
//   CAPTURE (1 cycle): RESP<=CUT_OUT, RESP_VALID<=1 next cycle, VEC_CNT<=VEC_CNT+1, lfsr steps.
//    Next state is DONE if VEC_CNT+1==NUM_VEC, else APPLY.
//  Per-vector latency is 2+SETTLE_CYC cycles. DONE rises NUM_VEC*(2+SETTLE_CYC) cycles after the START edge.
//  START while BUSY is ignored, with no effect on state or counters.
//  NUM_VEC > 2^IN_W-1: the vector sequence wraps and repeats. This is legal. VEC_CNT never wraps.
//  Outputs are registered only; there are no combinational paths from CUT_OUT or START to any output.
// CONFIGURATION
//  CUT_BIST_MISR_EN defined:
//   each CAPTURE also does sig <= {sig[OUT_W-2:0], ^(sig & MISR_TAPS)} ^ CUT_OUT.
//   SIG holds the value from DONE until the next START.
//  CUT_BIST_MISR_EN undefined: the SIG port and MISR logic are absent. RESP/RESP_VALID are the only response path.
// TESTING (defaults unless stated; loopback = CUT_OUT tied to CUT_IN)
//  1. Loopback, NUM_VEC=5, START pulse -> CUT_IN sequence 01,02,04,08,11; RESP_VALID pulses 5 times;
//     RESP values are 01,02,04,08,11; DONE=1 with VEC_CNT=5.
//  2. NUM_VEC=4, SETTLE_CYC=2 -> BUSY high exactly 16 cycles; DONE rises 16 cycles after the START edge.
//     SETTLE_CYC=0 -> 8 cycles.
//  3. START re-pulsed mid-run at vector 2 -> ignored; run completes with VEC_CNT=NUM_VEC.
//     RST at vector 2 -> next cycle all outputs at reset values, CUT_IN=01.
//  4. NUM_VEC=0, START -> BUSY never asserts; DONE=1 the next cycle; RESP_VALID never pulses.
//  5. CUT_BIST_MISR_EN defined, loopback, NUM_VEC=3 -> SIG=8'h04 at DONE.
//     Flip one CUT_OUT bit during the 2nd capture -> SIG!=8'h04.
//  6. DONE held, then a second START -> DONE drops next cycle; the run repeats the identical CUT_IN sequence from SEED.

Source files
------------

// File: rtl/cut_bist_driver.sv
// cut_bist_driver: LFSR-driven BIST harness for a combinational circuit-under-test with programmable settle time.
// Optional MISR response signature (sig_o) is built only when CUT_BIST_MISR_EN is defined.
module cut_bist_driver #(
    parameter int unsigned      IN_W       = 8,
    parameter int unsigned      OUT_W      = 8,
    parameter logic [IN_W-1:0]  SEED       = 8'h01,
    parameter logic [IN_W-1:0]  TAPS       = 8'hB8,
    parameter logic [OUT_W-1:0] MISR_TAPS  = 8'hB8,
    parameter int unsigned      SETTLE_CYC = 2,
    parameter int unsigned      NUM_VEC    = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    output logic [IN_W-1:0]  cut_in_o,
    input  logic [OUT_W-1:0] cut_out_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [15:0]      vec_cnt_o,
    output logic [OUT_W-1:0] resp_o,
    output logic             resp_valid_o
`ifdef CUT_BIST_MISR_EN
    ,
    output logic [OUT_W-1:0] sig_o
`endif
);

    localparam logic [7:0]  SETTLE_LD = 8'(SETTLE_CYC);
    localparam logic [15:0] NUM_VEC_L = 16'(NUM_VEC);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_APPLY   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    function automatic logic [IN_W-1:0] lfsr_next(input logic [IN_W-1:0] v);
        return {v[IN_W-2:0], ^(v & TAPS)};
    endfunction

`ifdef CUT_BIST_MISR_EN
    function automatic logic [OUT_W-1:0] misr_next(input logic [OUT_W-1:0] s,
                                                   input logic [OUT_W-1:0] d);
        return {s[OUT_W-2:0], ^(s & MISR_TAPS)} ^ d;
    endfunction
`endif

    state_t            state_q, state_d;
    logic [IN_W-1:0]   lfsr_q, lfsr_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [15:0]       vec_cnt_q, vec_cnt_d;
    logic [OUT_W-1:0]  resp_q, resp_d;
    logic              resp_valid_q, resp_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              start_acc_s;
`ifdef CUT_BIST_MISR_EN
    logic [OUT_W-1:0]  sig_q, sig_d;
`endif

    // Next-state and datapath decode for the apply/settle/capture sequencer
    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        cnt_d        = cnt_q;
        vec_cnt_d    = vec_cnt_q;
        resp_d       = resp_q;
        resp_valid_d = 1'b0;
        start_acc_s  = 1'b0;
`ifdef CUT_BIST_MISR_EN
        sig_d        = sig_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    start_acc_s = 1'b1;
                    lfsr_d      = SEED;
                    vec_cnt_d   = 16'd0;
`ifdef CUT_BIST_MISR_EN
                    sig_d       = {OUT_W{1'b0}};
`endif
                    if (NUM_VEC_L == 16'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_APPLY;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_APPLY: begin
                cnt_d = SETTLE_LD;
                if (SETTLE_LD == 8'd0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                // Leave on the cycle the counter reaches zero, so SETTLE lasts SETTLE_CYC cycles
                cnt_d = cnt_q - 8'd1;
                if (cnt_q <= 8'd1) begin
                    state_d = ST_CAPTURE;
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            ST_CAPTURE: begin
                resp_d       = cut_out_i;
                resp_valid_d = 1'b1;
                vec_cnt_d    = vec_cnt_q + 16'd1;
                lfsr_d       = lfsr_next(lfsr_q);
`ifdef CUT_BIST_MISR_EN
                sig_d        = misr_next(sig_q, cut_out_i);
`endif
                if ((vec_cnt_q + 16'd1) == NUM_VEC_L) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_APPLY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status flags follow the next state so they change on the same edge as the FSM
        busy_d = (state_d == ST_APPLY) || (state_d == ST_SETTLE) || (state_d == ST_CAPTURE);
        done_d = (state_d == ST_DONE) && !start_acc_s;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            lfsr_q       <= SEED;
            cnt_q        <= 8'd0;
            vec_cnt_q    <= 16'd0;
            resp_q       <= {OUT_W{1'b0}};
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef CUT_BIST_MISR_EN
            sig_q        <= {OUT_W{1'b0}};
`endif
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            cnt_q        <= cnt_d;
            vec_cnt_q    <= vec_cnt_d;
            resp_q       <= resp_d;
            resp_valid_q <= resp_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef CUT_BIST_MISR_EN
            sig_q        <= sig_d;
`endif
        end
    end

    assign cut_in_o     = lfsr_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign vec_cnt_o    = vec_cnt_q;
    assign resp_o       = resp_q;
    assign resp_valid_o = resp_valid_q;
`ifdef CUT_BIST_MISR_EN
    assign sig_o        = sig_q;
`endif

endmodule

// File: tb/tb_cut_bist_driver.sv
// Self-checking bench for cut_bist_driver: four instances with different NUM_VEC/SETTLE_CYC, CUT in loopback.
// MISR checks are included when CUT_BIST_MISR_EN is defined.
module tb_cut_bist_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst;
    logic [3:0] start;
    logic       flip_en;

    // a: NUM_VEC=5 SETTLE=2, b: NUM_VEC=4 SETTLE=0, c: NUM_VEC=0, d: NUM_VEC=4 SETTLE=2
    logic [7:0]  cin_a, cin_b, cin_c, cin_d, cout_a, flip_a;
    logic [7:0]  resp_a, resp_b, resp_c, resp_d;
    logic        busy_a, busy_b, busy_c, busy_d;
    logic        done_a, done_b, done_c, done_d;
    logic        rv_a, rv_b, rv_c, rv_d;
    logic [15:0] cnt_a, cnt_b, cnt_c, cnt_d;
`ifdef CUT_BIST_MISR_EN
    logic [7:0]  sig_a, sig_b, sig_c, sig_d;
`endif

    assign flip_a = (flip_en && cnt_a == 16'd1) ? 8'h01 : 8'h00;
    assign cout_a = cin_a ^ flip_a;

    cut_bist_driver #(.NUM_VEC(5), .SETTLE_CYC(2)) u_a (
        .clk_i(clk), .rst_i(rst), .start_i(start[0]), .cut_in_o(cin_a), .cut_out_i(cout_a),
        .busy_o(busy_a), .done_o(done_a), .vec_cnt_o(cnt_a), .resp_o(resp_a), .resp_valid_o(rv_a)
`ifdef CUT_BIST_MISR_EN
        , .sig_o(sig_a)
`endif
    );
    cut_bist_driver #(.NUM_VEC(4), .SETTLE_CYC(0)) u_b (
        .clk_i(clk), .rst_i(rst), .start_i(start[1]), .cut_in_o(cin_b), .cut_out_i(cin_b),
        .busy_o(busy_b), .done_o(done_b), .vec_cnt_o(cnt_b), .resp_o(resp_b), .resp_valid_o(rv_b)
`ifdef CUT_BIST_MISR_EN
        , .sig_o(sig_b)
`endif
    );
    cut_bist_driver #(.NUM_VEC(0), .SETTLE_CYC(2)) u_c (
        .clk_i(clk), .rst_i(rst), .start_i(start[2]), .cut_in_o(cin_c), .cut_out_i(cin_c),
        .busy_o(busy_c), .done_o(done_c), .vec_cnt_o(cnt_c), .resp_o(resp_c), .resp_valid_o(rv_c)
`ifdef CUT_BIST_MISR_EN
        , .sig_o(sig_c)
`endif
    );
    cut_bist_driver #(.NUM_VEC(4), .SETTLE_CYC(2)) u_d (
        .clk_i(clk), .rst_i(rst), .start_i(start[3]), .cut_in_o(cin_d), .cut_out_i(cin_d),
        .busy_o(busy_d), .done_o(done_d), .vec_cnt_o(cnt_d), .resp_o(resp_d), .resp_valid_o(rv_d)
`ifdef CUT_BIST_MISR_EN
        , .sig_o(sig_d)
`endif
    );

    int busy_cnt_a = 0, busy_cnt_b = 0, busy_cnt_c = 0, busy_cnt_d = 0;
    int rv_cnt_a = 0, rv_cnt_c = 0;
    always @(negedge clk) begin
        if (busy_a) busy_cnt_a <= busy_cnt_a + 1;
        if (busy_b) busy_cnt_b <= busy_cnt_b + 1;
        if (busy_c) busy_cnt_c <= busy_cnt_c + 1;
        if (busy_d) busy_cnt_d <= busy_cnt_d + 1;
        if (rv_a)   rv_cnt_a   <= rv_cnt_a + 1;
        if (rv_c)   rv_cnt_c   <= rv_cnt_c + 1;
    end

    typedef struct {
        logic [7:0]  resp;
        logic [15:0] cnt;
        logic [7:0]  cin_after;
        int          dcyc;
    } vec_t;
    vec_t tbl [5];

    int checks = 0;
    int errors = 0;
    int t0 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_start(input int idx);
        @(negedge clk);
        start[idx] = 1'b1;
        @(negedge clk);
        start[idx] = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(input int idx, input int bound);
        int n = 0;
        logic d;
        d = (idx == 0) ? done_a : (idx == 1) ? done_b : (idx == 2) ? done_c : done_d;
        while (!d && n < bound) begin
            @(negedge clk);
            n++;
            d = (idx == 0) ? done_a : (idx == 1) ? done_b : (idx == 2) ? done_c : done_d;
        end
        chk("done_seen", {31'd0, d}, 32'd1);
    endtask

    task automatic wait_cnt_a(input logic [15:0] target);
        int n = 0;
        while (cnt_a != target && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("wait_vec_cnt", {16'd0, cnt_a}, {16'd0, target});
    endtask

    // Walk instance a through a full run from the START negedge, checking each response pulse
    task automatic run_table_a();
        for (int i = 0; i < 5; i++) begin
            int n = 0;
            @(negedge clk);
            while (!rv_a && n < 10) begin
                @(negedge clk);
                n++;
            end
            chk("rv_seen",     {31'd0, rv_a}, 32'd1);
            chk("rv_time",     cyc - t0, tbl[i].dcyc);
            chk("resp",        {24'd0, resp_a}, {24'd0, tbl[i].resp});
            chk("vec_cnt",     {16'd0, cnt_a}, {16'd0, tbl[i].cnt});
            chk("cut_in_next", {24'd0, cin_a}, {24'd0, tbl[i].cin_after});
        end
        wait_done(0, 10);
        chk("done_time_a", cyc - t0, 32'd20);
        chk("done_cnt_a",  {16'd0, cnt_a}, 32'd5);
        chk("done_busy_a", {31'd0, busy_a}, 32'd0);
    endtask

`ifdef CUT_BIST_MISR_EN
    function automatic logic [7:0] misr_model(input logic [7:0] s, input logic [7:0] d);
        return {s[6:0], ^(s & 8'hB8)} ^ d;
    endfunction
`endif

    initial begin
        int b0, b1, r0;
        tbl[0] = '{8'h01, 16'd1, 8'h02, 4};
        tbl[1] = '{8'h02, 16'd2, 8'h04, 8};
        tbl[2] = '{8'h04, 16'd3, 8'h08, 12};
        tbl[3] = '{8'h08, 16'd4, 8'h11, 16};
        tbl[4] = '{8'h11, 16'd5, 8'h23, 20};

        rst = 1'b1;
        start = 4'b0000;
        flip_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy",   {31'd0, busy_a}, 32'd0);
        chk("rst_done",   {31'd0, done_a}, 32'd0);
        chk("rst_cnt",    {16'd0, cnt_a}, 32'd0);
        chk("rst_resp",   {24'd0, resp_a}, 32'd0);
        chk("rst_rv",     {31'd0, rv_a}, 32'd0);
        chk("rst_cut_in", {24'd0, cin_a}, 32'h01);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Loopback run, 5 vectors, with busy/pulse counting
        b0 = busy_cnt_a;
        r0 = rv_cnt_a;
        pulse_start(0);
        chk("start_busy_a", {31'd0, busy_a}, 32'd1);
        chk("start_cin_a",  {24'd0, cin_a}, 32'h01);
        run_table_a();
        repeat (2) @(negedge clk);
        chk("busy_cycles_a", busy_cnt_a - b0, 32'd20);
        chk("rv_pulses_a",   rv_cnt_a - r0, 32'd5);
        chk("done_held_a",   {31'd0, done_a}, 32'd1);

        // Second START from DONE repeats the sequence from SEED
        pulse_start(0);
        chk("restart_done_a", {31'd0, done_a}, 32'd0);
        chk("restart_cin_a",  {24'd0, cin_a}, 32'h01);
        chk("restart_cnt_a",  {16'd0, cnt_a}, 32'd0);
        run_table_a();

        // START while busy is ignored
        pulse_start(0);
        wait_cnt_a(16'd2);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        wait_done(0, 40);
        chk("ignore_done_time", cyc - t0, 32'd20);
        chk("ignore_cnt",       {16'd0, cnt_a}, 32'd5);

        // Reset mid-run
        pulse_start(0);
        wait_cnt_a(16'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy",   {31'd0, busy_a}, 32'd0);
        chk("midrst_done",   {31'd0, done_a}, 32'd0);
        chk("midrst_cnt",    {16'd0, cnt_a}, 32'd0);
        chk("midrst_resp",   {24'd0, resp_a}, 32'd0);
        chk("midrst_rv",     {31'd0, rv_a}, 32'd0);
        chk("midrst_cut_in", {24'd0, cin_a}, 32'h01);
        repeat (6) @(negedge clk);
        chk("midrst_idle_busy", {31'd0, busy_a}, 32'd0);
        chk("midrst_idle_cin",  {24'd0, cin_a}, 32'h01);

`ifdef CUT_BIST_MISR_EN
        begin
            logic [7:0] s_good, s_flip;
            s_good = 8'h00;
            s_flip = 8'h00;
            for (int i = 0; i < 5; i++) begin
                s_good = misr_model(s_good, tbl[i].resp);
                s_flip = misr_model(s_flip, (i == 1) ? (tbl[i].resp ^ 8'h01) : tbl[i].resp);
            end
            pulse_start(0);
            chk("sig_cleared", {24'd0, sig_a}, 32'h00);
            wait_done(0, 40);
            chk("sig_good",  {24'd0, sig_a}, {24'd0, s_good});
            repeat (3) @(negedge clk);
            chk("sig_held",  {24'd0, sig_a}, {24'd0, s_good});
            flip_en = 1'b1;
            pulse_start(0);
            wait_done(0, 40);
            flip_en = 1'b0;
            chk("sig_flip",  {24'd0, sig_a}, {24'd0, s_flip});
            chk("sig_differs", {31'd0, (sig_a != s_good)}, 32'd1);
        end
`endif

        // NUM_VEC=4, SETTLE=2: 16 busy cycles
        b1 = busy_cnt_d;
        pulse_start(3);
        wait_done(3, 40);
        chk("done_time_d", cyc - t0, 32'd16);
        chk("done_cnt_d",  {16'd0, cnt_d}, 32'd4);
        repeat (2) @(negedge clk);
        chk("busy_cycles_d", busy_cnt_d - b1, 32'd16);
        chk("resp_last_d",   {24'd0, resp_d}, 32'h08);

        // NUM_VEC=4, SETTLE=0: 8 busy cycles
        b1 = busy_cnt_b;
        pulse_start(1);
        wait_done(1, 40);
        chk("done_time_b", cyc - t0, 32'd8);
        chk("done_cnt_b",  {16'd0, cnt_b}, 32'd4);
        repeat (2) @(negedge clk);
        chk("busy_cycles_b", busy_cnt_b - b1, 32'd8);
        chk("resp_last_b",   {24'd0, resp_b}, 32'h08);

        // NUM_VEC=0: straight to DONE, never busy
        b0 = busy_cnt_c;
        r0 = rv_cnt_c;
        pulse_start(2);
        chk("nv0_done_first", {31'd0, done_c}, 32'd0);
        @(negedge clk);
        chk("nv0_done_next",  {31'd0, done_c}, 32'd1);
        repeat (4) @(negedge clk);
        chk("nv0_busy",  busy_cnt_c - b0, 32'd0);
        chk("nv0_rv",    rv_cnt_c - r0, 32'd0);
        chk("nv0_held",  {31'd0, done_c}, 32'd1);
        chk("nv0_cnt",   {16'd0, cnt_c}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
